// File: rtl/reader_pkg.sv
// Shared definitions for the reader_multi fetch/execute core: opcodes,
// instruction word layout and FSM state encoding.
package reader_pkg;

    localparam int unsigned OPC_W = 8;

    localparam logic [OPC_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OPC_W-1:0] OP_MOVI = 8'h01;
    localparam logic [OPC_W-1:0] OP_MOV  = 8'h02;
    localparam logic [OPC_W-1:0] OP_ADD  = 8'h03;
    localparam logic [OPC_W-1:0] OP_SUB  = 8'h04;
    localparam logic [OPC_W-1:0] OP_JMP  = 8'h05;
    localparam logic [OPC_W-1:0] OP_JZ   = 8'h06;
    localparam logic [OPC_W-1:0] OP_HALT = 8'h07;

    // Field positions: opcode [31:24], rd [23:16], rs [15:8], imm [7:0]
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] rd;
        logic [7:0] rs;
        logic [7:0] imm;
    } instr_t;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/reader_multi_if.sv
// Instruction-memory fetch handshake between the core (master) and memory (slave).
interface reader_multi_if #(
    parameter int unsigned IP_W = 8
);
    import reader_pkg::*;

    logic            mem_req;
    logic [IP_W-1:0] mem_addr;
    logic            mem_ack;
    instr_t          mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);

endinterface

// File: rtl/reader_regfile.sv
// NUM_REGS x DATA_W register file: one synchronous write port, two operand
// read ports and one debug read port, all reads combinational.
module reader_regfile #(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 4,
    localparam int unsigned SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [SEL_W-1:0]  raddr_a_i,
    input  logic [SEL_W-1:0]  raddr_b_i,
    input  logic [SEL_W-1:0]  dbg_sel_i,
    output logic [DATA_W-1:0] rdata_a_c_o,
    output logic [DATA_W-1:0] rdata_b_c_o,
    output logic [DATA_W-1:0] dbg_data_c_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_c_o  = regs_q[raddr_a_i];
    assign rdata_b_c_o  = regs_q[raddr_b_i];
    assign dbg_data_c_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/reader_multi.sv
// Multi-cycle fetch/execute core with a req/ack instruction fetch port.
// Define READER_TRACE_EN to expose a retired-instruction counter on debug.
module reader_multi
    import reader_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned IP_W     = 8,
    parameter  int unsigned NUM_REGS = 4,
    localparam int unsigned SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    reader_multi_if.master    mem,
    output logic [IP_W-1:0]   iPointer,
    output logic [7:0]        opCode,
    output logic              halted,
    output logic              illegal,
    input  logic [SEL_W-1:0]  reg_sel,
    output logic [DATA_W-1:0] reg_value,
    output logic [31:0]       debug
);

    logic [1:0]        state_q, state_d;
    logic [IP_W-1:0]   ip_q, ip_d, ip_inc;
    instr_t            instr_q, instr_d;
    logic              req_q, req_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_val, rs_val;
    logic [SEL_W-1:0]  rd_sel, rs_sel;
    logic              unused_sel_bits;

    // Only the low SEL_W bits of rd/rs address a register
    assign rd_sel          = instr_q.rd[SEL_W-1:0];
    assign rs_sel          = instr_q.rs[SEL_W-1:0];
    assign unused_sel_bits = ^{instr_q.rd[7:SEL_W], instr_q.rs[7:SEL_W]};
    assign ip_inc          = ip_q + IP_W'(1);

    reader_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .we_i         (wr_en),
        .waddr_i      (rd_sel),
        .wdata_i      (wr_data),
        .raddr_a_i    (rd_sel),
        .raddr_b_i    (rs_sel),
        .dbg_sel_i    (reg_sel),
        .rdata_a_c_o  (rd_val),
        .rdata_b_c_o  (rs_val),
        .dbg_data_c_o (reg_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ip_q      <= '0;
            instr_q   <= '0;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // FETCH raises req (held until ack), EXEC retires one instruction, HALT is terminal
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        instr_d   = instr_q;
        req_d     = req_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        wr_en     = 1'b0;
        wr_data   = '0;

        case (state_q)
            ST_FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (mem.mem_ack) begin
                    instr_d = mem.mem_data;
                    req_d   = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                ip_d    = ip_inc;
                case (instr_q.opcode)
                    OP_NOP: ;
                    OP_MOVI: begin
                        wr_en   = 1'b1;
                        wr_data = DATA_W'(instr_q.imm);
                    end
                    OP_MOV: begin
                        wr_en   = 1'b1;
                        wr_data = rs_val;
                    end
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + rs_val;
                    end
                    OP_SUB: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val - rs_val;
                    end
                    OP_JMP: ip_d = IP_W'(instr_q.imm);
                    OP_JZ: begin
                        if (rd_val == '0) ip_d = IP_W'(instr_q.imm);
                    end
                    OP_HALT: begin
                        state_d  = ST_HALT;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                        ip_d     = ip_q;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = ip_q;
    assign iPointer     = ip_q;
    assign opCode       = instr_q.opcode;
    assign halted       = halted_q;
    assign illegal      = illegal_q;

`ifdef READER_TRACE_EN
    logic [31:0] retired_q;

    // Counts every EXEC edge, HALT included; wraps silently
    always_ff @(posedge clk) begin
        if (reset)                  retired_q <= '0;
        else if (state_q == ST_EXEC) retired_q <= retired_q + 32'd1;
    end

    assign debug = retired_q;
`else
    assign debug = '0;
`endif

endmodule

// File: tb/tb_reader_multi.sv
// Self-checking bench for reader_multi: directed programs, an 8-bit datapath
// vector table and random programs checked against an instruction-level model.
module tb_reader_multi;
    import reader_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned IPW = 8;
    localparam int unsigned NR  = 4;
`ifdef READER_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic [IPW-1:0]  ip, ip8;
    logic [7:0]      opc, opc8;
    logic            halted, illegal, halted8, illegal8;
    logic [1:0]      reg_sel = '0, sel8 = '0;
    logic [DW-1:0]   reg_value;
    logic [7:0]      val8;
    logic [31:0]     debug, debug8;

    reader_multi_if #(.IP_W(IPW)) m  ();
    reader_multi_if #(.IP_W(IPW)) m8 ();

    reader_multi #(.DATA_W(DW), .IP_W(IPW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .mem(m), .iPointer(ip), .opCode(opc), .halted(halted),
        .illegal(illegal), .reg_sel(reg_sel), .reg_value(reg_value), .debug(debug));

    reader_multi #(.DATA_W(8), .IP_W(IPW), .NUM_REGS(NR)) dut8 (
        .clk(clk), .reset(reset), .mem(m8), .iPointer(ip8), .opCode(opc8), .halted(halted8),
        .illegal(illegal8), .reg_sel(sel8), .reg_value(val8), .debug(debug8));

    int n_vec = 0, n_err = 0;

    logic [31:0] imem  [256];
    logic [31:0] imem8 [256];
    bit          resp_en = 1'b1;
    int          ack_delay = 0, wcnt = 0, stab_err = 0, req_cycles = 0, hs8 = 0;
    logic [7:0]  first_addr = '0;
    logic        man_ack = 1'b0;
    logic [31:0] man_data = '0;
    logic [7:0]  fetch_q [$];

    // Memory responder for the main core: ack after ack_delay waiting cycles
    always @(negedge clk) begin
        if (!resp_en) begin
            m.mem_ack  = man_ack;
            m.mem_data = instr_t'(man_data);
            wcnt       = 0;
        end else if (m.mem_req) begin
            if (wcnt == 0) first_addr = m.mem_addr;
            else if (m.mem_addr != first_addr) stab_err++;
            req_cycles++;
            if (wcnt >= ack_delay) begin
                m.mem_ack  = 1'b1;
                m.mem_data = instr_t'(imem[m.mem_addr]);
                fetch_q.push_back(m.mem_addr);
                wcnt = 0;
            end else begin
                m.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            if (wcnt != 0) stab_err++;
            m.mem_ack = 1'b0;
            wcnt      = 0;
        end
    end

    always @(negedge clk) begin
        if (m8.mem_req) begin
            m8.mem_ack  = 1'b1;
            m8.mem_data = instr_t'(imem8[m8.mem_addr]);
            hs8++;
        end else begin
            m8.mem_ack = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rd,
                                        input logic [7:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] exp_dbg(input int n);
        return TRACE ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = ins(8'h07, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic run_to_halt(input int maxc, input string name);
        int c = 0;
        while (!halted && c < maxc) begin
            tick();
            c++;
        end
        if (!halted) timeout_fail(name);
    endtask

    task automatic rd_reg(input int i, output logic [31:0] v);
        reg_sel = 2'(i);
        #1;
        v = reg_value;
    endtask

    task automatic step8(input string name);
        int h0 = hs8;
        int c  = 0;
        while (hs8 == h0 && c < 50) begin
            tick();
            c++;
        end
        if (hs8 == h0) timeout_fail(name);
        else tick();
    endtask

    // Instruction-level reference: interprets imem until HALT
    logic [31:0] m_r [4];
    int          m_ip, m_ret;
    bit          m_ill;

    task automatic model_run();
        int pc = 0;
        logic [31:0] w;
        logic [7:0] op, imm;
        int d, s;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_ill = 1'b0;
        m_ret = 0;
        for (int g = 0; g < 1000; g++) begin
            w   = imem[pc];
            op  = w[31:24];
            d   = int'(w[23:16]) % 4;
            s   = int'(w[15:8]) % 4;
            imm = w[7:0];
            m_ret++;
            if (op == 8'h07) break;
            case (op)
                8'h00, 8'h05, 8'h06: ;
                8'h01: m_r[d] = 32'(imm);
                8'h02: m_r[d] = m_r[s];
                8'h03: m_r[d] = m_r[d] + m_r[s];
                8'h04: m_r[d] = m_r[d] - m_r[s];
                default: m_ill = 1'b1;
            endcase
            if (op == 8'h05 || (op == 8'h06 && m_r[d] == 0)) pc = int'(imm);
            else pc = (pc + 1) % 256;
        end
        m_ip = pc;
    endtask

    typedef struct {
        logic [31:0] instr;
        int          sel;
        logic [7:0]  exp_val;
        logic [7:0]  exp_ip;
    } vec8_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec8_t       tbl [10];
        logic [31:0] v;
        int          L;
        logic [7:0]  op, rd, rs, imm;

        tbl[0] = '{ins(8'h01, 8'h00, 8'h00, 8'hFF), 0, 8'hFF, 8'd1};
        tbl[1] = '{ins(8'h01, 8'h01, 8'h00, 8'h01), 1, 8'h01, 8'd2};
        tbl[2] = '{ins(8'h03, 8'h00, 8'h01, 8'h00), 0, 8'h00, 8'd3};
        tbl[3] = '{ins(8'h04, 8'h00, 8'h01, 8'h00), 0, 8'hFF, 8'd4};
        tbl[4] = '{ins(8'h02, 8'hF6, 8'hFC, 8'h00), 2, 8'hFF, 8'd5};
        tbl[5] = '{ins(8'h04, 8'h03, 8'h01, 8'h00), 3, 8'hFF, 8'd6};
        tbl[6] = '{ins(8'h06, 8'h00, 8'h00, 8'h20), 0, 8'hFF, 8'd7};
        tbl[7] = '{ins(8'h03, 8'h01, 8'h01, 8'h00), 1, 8'h02, 8'd8};
        tbl[8] = '{ins(8'h01, 8'h02, 8'h00, 8'h00), 2, 8'h00, 8'd9};
        tbl[9] = '{ins(8'h06, 8'h02, 8'h00, 8'h0B), 2, 8'h00, 8'h0B};

        for (int i = 0; i < 256; i++) imem8[i] = ins(8'h07, 8'h00, 8'h00, 8'h00);
        fill_halt();

        // Program A, ack on first req cycle
        imem[0] = ins(8'h01, 8'h00, 8'h00, 8'h05);
        imem[1] = ins(8'h01, 8'h01, 8'h00, 8'h03);
        imem[2] = ins(8'h03, 8'h00, 8'h01, 8'h00);
        imem[3] = ins(8'h07, 8'h00, 8'h00, 8'h00);
        ack_delay = 0;
        do_reset();
        chk("rst_ip", ip, 0);
        chk("rst_opcode", opc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mem_req", m.mem_req, 0);
        chk("rst_debug", debug, 0);
        tick();
        chk("first_req", m.mem_req, 1);
        chk("first_addr", m.mem_addr, 0);
        run_to_halt(100, "progA");
        rd_reg(0, v); chk("progA_r0", v, 8);
        rd_reg(1, v); chk("progA_r1", v, 3);
        chk("progA_halted", halted, 1);
        chk("progA_ip", ip, 3);
        chk("progA_opcode", opc, 8'h07);
        chk("progA_debug", debug, exp_dbg(4));
        chk("progA_halt_req", m.mem_req, 0);

        // Same program, ack delayed 3 cycles on every fetch
        ack_delay  = 3;
        stab_err   = 0;
        do_reset();
        req_cycles = 0;
        rd_reg(0, v); chk("rst_r0_cleared", v, 0);
        run_to_halt(200, "progA_slow");
        rd_reg(0, v); chk("slow_r0", v, 8);
        rd_reg(1, v); chk("slow_r1", v, 3);
        chk("slow_ip", ip, 3);
        chk("slow_req_cycles", 64'(req_cycles), 16);
        chk("slow_stable", 64'(stab_err), 0);

        // Countdown loop with JZ exit
        fill_halt();
        imem[0] = ins(8'h01, 8'h02, 8'h00, 8'h03);
        imem[1] = ins(8'h01, 8'h03, 8'h00, 8'h01);
        imem[2] = ins(8'h04, 8'h02, 8'h03, 8'h00);
        imem[3] = ins(8'h06, 8'h02, 8'h00, 8'h05);
        imem[4] = ins(8'h05, 8'h00, 8'h00, 8'h02);
        ack_delay = 1;
        do_reset();
        run_to_halt(300, "loop");
        chk("loop_ip", ip, 5);
        rd_reg(2, v); chk("loop_r2", v, 0);
        rd_reg(3, v); chk("loop_r3", v, 1);
        chk("loop_debug", debug, exp_dbg(11));

        // ip wrap: JMP 0xFF, NOP at 0xFF, next fetch at 0x00
        fill_halt();
        imem[0]   = ins(8'h06, 8'h01, 8'h00, 8'h02);
        imem[2]   = ins(8'h01, 8'h01, 8'h00, 8'h01);
        imem[3]   = ins(8'h05, 8'h00, 8'h00, 8'hFF);
        imem[255] = ins(8'h00, 8'h00, 8'h00, 8'h00);
        ack_delay = 0;
        do_reset();
        fetch_q.delete();
        run_to_halt(200, "wrap");
        chk("wrap_nfetch", 64'(fetch_q.size()), 6);
        if (fetch_q.size() == 6) begin
            chk("wrap_f0", fetch_q[0], 8'h00);
            chk("wrap_f1", fetch_q[1], 8'h02);
            chk("wrap_f2", fetch_q[2], 8'h03);
            chk("wrap_f3", fetch_q[3], 8'hFF);
            chk("wrap_f4", fetch_q[4], 8'h00);
            chk("wrap_f5", fetch_q[5], 8'h01);
        end
        chk("wrap_ip", ip, 1);

        // Undefined opcode, then reset mid-fetch with simultaneous ack
        fill_halt();
        imem[0] = ins(8'h3C, 8'h00, 8'h00, 8'h00);
        ack_delay = 0;
        do_reset();
        run_to_halt(100, "illegal");
        chk("ill_flag", illegal, 1);
        chk("ill_ip", ip, 1);
        chk("ill_debug", debug, exp_dbg(2));
        imem[1] = ins(8'h01, 8'h00, 8'h00, 8'h55);
        do_reset();
        begin
            int c = 0;
            while (!illegal && c < 20) begin
                tick();
                c++;
            end
            if (!illegal) timeout_fail("ill_wait");
        end
        ack_delay = 20;
        tick();
        tick();
        chk("pend_req", m.mem_req, 1);
        chk("pend_addr", m.mem_addr, 1);
        reset    = 1'b1;
        resp_en  = 1'b0;
        man_ack  = 1'b1;
        man_data = ins(8'h01, 8'h00, 8'h00, 8'h77);
        tick();
        chk("rstack_ip", ip, 0);
        chk("rstack_illegal", illegal, 0);
        chk("rstack_req", m.mem_req, 0);
        chk("rstack_opcode", opc, 0);
        rd_reg(0, v); chk("rstack_r0", v, 0);
        man_ack   = 1'b0;
        resp_en   = 1'b1;
        ack_delay = 0;
        tick();
        reset = 1'b0;

        // 8-bit datapath vector table
        for (int i = 0; i < 10; i++) imem8[i] = tbl[i].instr;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step8($sformatf("dw8_step%0d", i));
            sel8 = 2'(tbl[i].sel);
            #1;
            chk($sformatf("dw8_val%0d", i), val8, tbl[i].exp_val);
            chk($sformatf("dw8_ip%0d", i), ip8, tbl[i].exp_ip);
        end
        step8("dw8_halt");
        chk("dw8_halted", halted8, 1);
        chk("dw8_halt_ip", ip8, 8'h0B);

        // Random forward-branching programs against the reference model
        for (int p = 0; p < 40; p++) begin
            fill_halt();
            L = int'($urandom_range(6, 20));
            for (int i = 0; i < L - 1; i++) begin
                rd  = 8'($urandom);
                rs  = 8'($urandom);
                imm = 8'($urandom);
                case ($urandom_range(0, 7))
                    0: op = 8'h00;
                    1: op = 8'h01;
                    2: op = 8'h02;
                    3: op = 8'h03;
                    4: op = 8'h04;
                    5: begin op = 8'h05; imm = 8'($urandom_range(i + 1, L - 1)); end
                    6: begin op = 8'h06; imm = 8'($urandom_range(i + 1, L - 1)); end
                    default: op = 8'($urandom_range(8, 255));
                endcase
                imem[i] = ins(op, rd, rs, imm);
            end
            model_run();
            ack_delay = int'($urandom_range(0, 3));
            do_reset();
            run_to_halt(2000, $sformatf("rnd%0d", p));
            for (int r = 0; r < 4; r++) begin
                rd_reg(r, v);
                chk($sformatf("rnd%0d_r%0d", p, r), v, m_r[r]);
            end
            chk($sformatf("rnd%0d_ip", p), ip, 64'(m_ip));
            chk($sformatf("rnd%0d_opcode", p), opc, 8'h07);
            chk($sformatf("rnd%0d_illegal", p), illegal, m_ill);
            chk($sformatf("rnd%0d_halted", p), halted, 1);
            chk($sformatf("rnd%0d_debug", p), debug, exp_dbg(m_ret));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
